// File: rtl/cast_d8_pkg.sv
// Shared 8-bit cast types, limits and the bias helper used by the
// U2S and S2U casts (XOR with 0x80 converts in either direction).
package cast_d8_pkg;

  typedef logic [7:0]        d8_u_t;
  typedef logic signed [7:0] d8_s_t;

  localparam int    D8_MIN  = -128;
  localparam int    D8_MAX  = 127;
  localparam d8_u_t D8_BIAS = 8'h80;

  function automatic d8_u_t d8_bias(d8_s_t v);
    return d8_u_t'(v) ^ D8_BIAS;
  endfunction

endpackage

// File: rtl/cast_d8_s2u_stream_if.sv
// Stream bundle for the S2U cast: input sample side and output pixel side.
// The master drives the samples in and accepts the pixels out.
interface cast_d8_s2u_stream_if #(
  parameter int IN_W = 16
);
  logic                   in_valid;
  logic                   in_ready;
  logic signed [IN_W-1:0] in_data;
  logic                   in_last;
  logic                   out_valid;
  logic                   out_ready;
  logic [7:0]             out_data;
  logic                   out_last;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/cast_d8_clamp.sv
// Clamp a W-bit signed value to int8 and bias it to an unsigned pixel,
// flagging which side (if any) was clipped.
module cast_d8_clamp
  import cast_d8_pkg::*;
#(
  parameter int W = 17
) (
  input  logic signed [W-1:0] i_val,
  output d8_u_t               o_data,
  output logic                o_sat_hi,
  output logic                o_sat_lo
);
  localparam logic signed [W-1:0] LIM_HI = W'(D8_MAX);
  localparam logic signed [W-1:0] LIM_LO = W'(D8_MIN);

  d8_s_t w_c;

  assign o_sat_hi = i_val > LIM_HI;
  assign o_sat_lo = i_val < LIM_LO;

  always_comb begin
    w_c = i_val[7:0];
    unique case (1'b1)
      o_sat_hi: w_c = d8_s_t'(D8_MAX);
      o_sat_lo: w_c = d8_s_t'(D8_MIN);
      default:  w_c = i_val[7:0];
    endcase
  end

  assign o_data = d8_bias(w_c);
endmodule

// File: rtl/cast_d8_s2u_stream.sv
// Round/shift, clamp and bias wide signed sums to 0..255 pixels in a
// 2-stage elastic pipe. CAST_D8_SAT_CNT_EN builds the saturation counters.
module cast_d8_s2u_stream
  import cast_d8_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int SHIFT = 2
) (
  input  logic                clk,
  input  logic                rst,
  cast_d8_s2u_stream_if.slave s,
  input  logic                clr_cnt,
  output logic [15:0]         sat_hi_cnt,
  output logic [15:0]         sat_lo_cnt
);
  localparam int RW  = IN_W + 1;
  localparam int RSH = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic signed [RW-1:0] RND =
    (SHIFT > 0) ? RW'(64'd1 << RSH) : '0;

  logic                 r_s1_v;
  logic                 r_s2_v;
  logic signed [RW-1:0] r_s1_d;
  logic                 r_s1_last;
  d8_u_t                r_out_data;
  logic                 r_out_last;

  logic                 w_adv2;
  logic signed [RW-1:0] w_ext;
  logic signed [RW-1:0] w_r;
  d8_u_t                w_c;
  logic                 w_sat_hi;
  logic                 w_sat_lo;
  logic                 w_load2;

  assign w_adv2     = !r_s2_v || s.out_ready;
  assign s.in_ready = !r_s1_v || w_adv2;
  assign w_load2    = w_adv2 && r_s1_v;

  // One guard bit keeps the rounding add from overflowing.
  assign w_ext = {s.in_data[IN_W-1], s.in_data};
  assign w_r   = (w_ext + RND) >>> SHIFT;

  cast_d8_clamp #(
    .W(RW)
  ) u_clamp (
    .i_val   (r_s1_d),
    .o_data  (w_c),
    .o_sat_hi(w_sat_hi),
    .o_sat_lo(w_sat_lo)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_v     <= 1'b0;
      r_s2_v     <= 1'b0;
      r_out_data <= '0;
      r_out_last <= 1'b0;
    end else begin
      if (s.in_ready) begin
        r_s1_v    <= s.in_valid;
        r_s1_d    <= w_r;
        r_s1_last <= s.in_last;
      end
      if (w_adv2) begin
        r_s2_v     <= r_s1_v;
        r_out_data <= w_c;
        r_out_last <= r_s1_last;
      end
    end
  end

  assign s.out_valid = r_s2_v;
  assign s.out_data  = r_out_data;
  assign s.out_last  = r_out_last;

`ifdef CAST_D8_SAT_CNT_EN
  logic [15:0] r_hi_cnt;
  logic [15:0] r_lo_cnt;

  always_ff @(posedge clk) begin
    if (rst || clr_cnt) begin
      r_hi_cnt <= '0;
      r_lo_cnt <= '0;
    end else if (w_load2) begin
      if (w_sat_hi && r_hi_cnt != 16'hFFFF)
        r_hi_cnt <= r_hi_cnt + 16'd1;
      if (w_sat_lo && r_lo_cnt != 16'hFFFF)
        r_lo_cnt <= r_lo_cnt + 16'd1;
    end
  end

  assign sat_hi_cnt = r_hi_cnt;
  assign sat_lo_cnt = r_lo_cnt;
`else
  logic w_unused;
  assign w_unused   = ^{clr_cnt, w_sat_hi, w_sat_lo, w_load2};
  assign sat_hi_cnt = '0;
  assign sat_lo_cnt = '0;
`endif
endmodule

// File: tb/tb_cast_d8_s2u_stream.sv
// Bench for cast_d8_s2u_stream: table vectors plus scoreboarded
// backpressure, reset and counter-limit sequences.
module tb_cast_d8_s2u_stream;
  localparam int IN_W  = 16;
  localparam int SHIFT = 2;

  typedef struct {
    logic signed [15:0] din;
    logic [7:0]         exp;
  } vec_t;

  typedef struct {
    logic [7:0] d;
    logic       l;
    int         t;
  } sb_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        clr_cnt;
  logic [15:0] sat_hi_cnt;
  logic [15:0] sat_lo_cnt;

  cast_d8_s2u_stream_if #(.IN_W(IN_W)) ifc ();

  cast_d8_s2u_stream #(
    .IN_W (IN_W),
    .SHIFT(SHIFT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .s         (ifc),
    .clr_cnt   (clr_cnt),
    .sat_hi_cnt(sat_hi_cnt),
    .sat_lo_cnt(sat_lo_cnt)
  );

  always #5 clk = ~clk;

  vec_t       tbl[10];
  sb_t        q[$];
  int         tests = 0;
  int         fails = 0;
  int         cyc = 0;
  int         n_out = 0;
  int         mhi = 0;
  int         mlo = 0;
  bit         chk_lat = 0;
  bit         cur_tbl = 0;
  logic [7:0] cur_exp = '0;
  bit         last_acc = 0;
  bit         saw_full = 0;
  bit         prev_stall = 0;
  logic [7:0] pd = '0;
  logic       pl = 1'b0;

  task automatic check(string nm, longint act, longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic int model_r(int x);
    int d;
    int t;
    d = 1 << SHIFT;
    t = x + ((SHIFT > 0) ? d / 2 : 0);
    if (t >= 0) return t / d;
    return -((-t + d - 1) / d);
  endfunction

  task automatic push(int x, logic l);
    int r;
    int c;
    r = model_r(x);
    c = (r > 127) ? 127 : (r < -128) ? -128 : r;
    if (r > 127 && mhi < 65535) mhi++;
    if (r < -128 && mlo < 65535) mlo++;
    q.push_back('{d: cur_tbl ? cur_exp : 8'(c + 128), l: l, t: cyc});
  endtask

  task automatic step();
    sb_t e;
    #1;
    if (prev_stall) begin
      check("hold_valid", ifc.out_valid, 1);
      check("hold_data", ifc.out_data, pd);
      check("hold_last", ifc.out_last, pl);
    end
    if (!ifc.in_ready) begin
      check("full_stall", {ifc.out_valid, ifc.out_ready}, 2'b10);
      saw_full = 1;
    end
`ifndef CAST_D8_SAT_CNT_EN
    check("cnt_off", {sat_hi_cnt, sat_lo_cnt}, 0);
`endif
    last_acc = ifc.in_valid && ifc.in_ready;
    if (last_acc) push(int'(ifc.in_data), ifc.in_last);
    if (ifc.out_valid && ifc.out_ready) begin
      n_out++;
      if (q.size() == 0) begin
        check("unexpected_out", ifc.out_data, -1);
      end else begin
        e = q.pop_front();
        check("out_data", ifc.out_data, e.d);
        check("out_last", ifc.out_last, e.l);
        if (chk_lat) check("latency", cyc - e.t, 2);
      end
    end
    prev_stall = ifc.out_valid && !ifc.out_ready;
    pd = ifc.out_data;
    pl = ifc.out_last;
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic drain();
    ifc.in_valid  = 1'b0;
    ifc.out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (q.size() == 0 && !ifc.out_valid) break;
      step();
    end
    check("drain_empty", q.size(), 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    int acc;
    tbl[0] = '{16'sd0,      8'h80};
    tbl[1] = '{16'sd2,      8'h81};
    tbl[2] = '{-16'sd2,     8'h80};
    tbl[3] = '{16'sd6,      8'h82};
    tbl[4] = '{-16'sd6,     8'h7F};
    tbl[5] = '{16'sd600,    8'hFF};
    tbl[6] = '{16'sd32767,  8'hFF};
    tbl[7] = '{-16'sd32768, 8'h00};
    tbl[8] = '{16'sd511,    8'hFF};
    tbl[9] = '{-16'sd512,   8'h00};

    rst           = 1'b1;
    clr_cnt       = 1'b0;
    ifc.in_valid  = 1'b0;
    ifc.in_data   = '0;
    ifc.in_last   = 1'b0;
    ifc.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    check("rst_out_valid", ifc.out_valid, 0);
    check("rst_out_data", ifc.out_data, 0);
    check("rst_out_last", ifc.out_last, 0);
    check("rst_in_ready", ifc.in_ready, 1);
    check("rst_hi_cnt", sat_hi_cnt, 0);
    check("rst_lo_cnt", sat_lo_cnt, 0);
    rst = 1'b0;

    // rounding, bias and saturation table at full rate
    chk_lat       = 1;
    ifc.out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      ifc.in_valid = 1'b1;
      ifc.in_data  = tbl[i].din;
      ifc.in_last  = (i == 9);
      cur_tbl      = 1;
      cur_exp      = tbl[i].exp;
      step();
    end
    drain();
    chk_lat = 0;
    cur_tbl = 0;
`ifdef CAST_D8_SAT_CNT_EN
    check("tbl_hi_cnt", sat_hi_cnt, 3);
    check("tbl_lo_cnt", sat_lo_cnt, 1);
`else
    check("tbl_hi_cnt", sat_hi_cnt, 0);
    check("tbl_lo_cnt", sat_lo_cnt, 0);
`endif

    // backpressure: out_ready low for cycles 3..8
    n0       = n_out;
    acc      = 0;
    saw_full = 0;
    for (int k = 0; k < 40 && acc < 10; k++) begin
      ifc.out_ready = !(k >= 3 && k <= 8);
      ifc.in_valid  = 1'b1;
      ifc.in_data   = 16'($urandom);
      ifc.in_last   = (acc == 9);
      step();
      if (last_acc) acc++;
    end
    ifc.in_last = 1'b0;
    drain();
    check("bp_count", n_out - n0, 10);
    check("bp_saw_full", saw_full, 1);
`ifdef CAST_D8_SAT_CNT_EN
    check("bp_hi_cnt", sat_hi_cnt, mhi);
    check("bp_lo_cnt", sat_lo_cnt, mlo);
`endif

    // reset with both stages full
    ifc.out_ready = 1'b0;
    ifc.in_valid  = 1'b1;
    ifc.in_data   = 16'sd700;
    for (int i = 0; i < 10; i++) begin
      if (!ifc.in_ready) break;
      step();
    end
    check("mid_full", ifc.in_ready, 0);
    ifc.in_valid = 1'b0;
    rst          = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("mid_out_valid", ifc.out_valid, 0);
    check("mid_out_data", ifc.out_data, 0);
    check("mid_in_ready", ifc.in_ready, 1);
    check("mid_hi_cnt", sat_hi_cnt, 0);
    check("mid_lo_cnt", sat_lo_cnt, 0);
    q.delete();
    mhi        = 0;
    mlo        = 0;
    prev_stall = 0;
    n0         = n_out;
    ifc.out_ready = 1'b1;
    repeat (4) step();
    check("mid_no_ghost", n_out - n0, 0);

    // counter ceiling then clear against a saturating load
    ifc.in_valid = 1'b1;
    ifc.in_data  = 16'sd32767;
    repeat (65540) step();
    drain();
`ifdef CAST_D8_SAT_CNT_EN
    check("lim_hi_cnt", sat_hi_cnt, 16'hFFFF);
`else
    check("lim_hi_cnt", sat_hi_cnt, 0);
`endif
    check("lim_lo_cnt", sat_lo_cnt, 0);
    ifc.in_valid = 1'b1;
    step();
    ifc.in_valid = 1'b0;
    clr_cnt      = 1'b1;
    step();
    clr_cnt = 1'b0;
    mhi     = 0;
    #1;
    check("clr_hi_cnt", sat_hi_cnt, 0);
    check("clr_lo_cnt", sat_lo_cnt, 0);
    drain();
    check("post_clr_hi", sat_hi_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
